// File: rtl/reg_writeback_seq_pkg.sv
// reg_writeback_seq_pkg: shared types for the register-file write-back sequencer
package reg_writeback_seq_pkg;
  localparam int WB_XLEN = 32;
  typedef logic [4:0] reg_addr_t;
  localparam reg_addr_t REG_ZERO = 5'd0;
  typedef struct packed {
    reg_addr_t rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/reg_writeback_seq_ld_tag_fifo.sv
// ld_tag_fifo: in-order circular buffer of outstanding load destinations
// Ports: push/push_rd enqueue a tag, pop dequeues head_rd; count is occupancy (0..DEPTH);
// match_rd_vec[q][e] flags valid, non-x0 entry e equal to query address q_rd[q].
module ld_tag_fifo
  import reg_writeback_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  reg_addr_t                   push_rd,
  input  reg_addr_t [2:0]             q_rd,
  output reg_addr_t                   head_rd,
  output logic [AW:0]                 count,
  output logic [2:0][DEPTH-1:0]       match_rd_vec
);
  reg_addr_t        ent [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    wp, rp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent   <= '{default: REG_ZERO};
      vld   <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        ent[wp] <= push_rd;
        vld[wp] <= 1'b1;
        wp      <= wp + 1'b1;
      end
      if (pop) begin
        vld[rp] <= 1'b0;
        rp      <= rp + 1'b1;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign head_rd = ent[rp];
  for (genvar q = 0; q < 3; q++) begin : g_q
    for (genvar e = 0; e < DEPTH; e++) begin : g_e
      assign match_rd_vec[q][e] = vld[e] && ent[e] != REG_ZERO && ent[e] == q_rd[q];
    end
  end
endmodule

// File: rtl/reg_writeback_seq.sv
// reg_writeback_seq: merges ALU results and in-order load responses onto the register-file write port
// Ports: alu_* ALU result handshake; ld_issue/ld_rd record a load, ld_rsp_* return its data;
// rs1/rs2 -> raw_stall hazard flag; AD3/WE3/WD3 registered write port; rsp_err sticky orphan-response flag.
module reg_writeback_seq
  import reg_writeback_seq_pkg::*;
#(
  parameter int LD_DEPTH = 4,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue,
  output logic            ld_issue_rdy,
  input  logic [4:0]      ld_rd,
  input  logic            ld_rsp_valid,
  input  logic [XLEN-1:0] ld_rsp_data,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            raw_stall,
  output logic [4:0]      AD3,
  output logic            WE3,
  output logic [XLEN-1:0] WD3,
  output logic            rsp_err
);
  localparam int CW = $clog2(LD_DEPTH) + 1;
  logic [CW-1:0]          count;
  logic [2:0][LD_DEPTH-1:0] match;
  reg_addr_t              head_rd;
  logic                   pop, alu_acc;
  wb_req_t                wb;
  ld_tag_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(ld_issue && ld_issue_rdy),
    .pop(pop),
    .push_rd(ld_rd),
    .q_rd({alu_rd, rs2, rs1}),
    .head_rd(head_rd),
    .count(count),
    .match_rd_vec(match)
  );
  assign ld_issue_rdy = count != CW'(LD_DEPTH);
  assign pop          = ld_rsp_valid && count != '0;
  assign raw_stall    = |match[0] || |match[1];
  // ALU waits behind any pending load to the same rd so writes stay in program order
  assign alu_ready    = !ld_rsp_valid && !(|match[2]);
  assign alu_acc      = alu_valid && alu_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WE3     <= 1'b0;
      wb      <= '0;
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= rsp_err || (ld_rsp_valid && !pop);
      WE3     <= pop ? head_rd != REG_ZERO : alu_acc && alu_rd != REG_ZERO;
      if (pop) wb <= '{rd: head_rd, data: ld_rsp_data};
      else if (alu_acc) wb <= '{rd: alu_rd, data: alu_data};
    end
  end
  assign AD3 = wb.rd;
  assign WD3 = wb.data;
endmodule

// File: tb/tb_reg_writeback_seq.sv
// tb_reg_writeback_seq: scoreboard bench for reg_writeback_seq
module tb_reg_writeback_seq;
  logic clk = 0, rst_n = 0;
  logic alu_valid = 0, alu_ready;
  logic [4:0] alu_rd = 0;
  logic [31:0] alu_data = 0;
  logic ld_issue = 0, ld_issue_rdy;
  logic [4:0] ld_rd = 0;
  logic ld_rsp_valid = 0;
  logic [31:0] ld_rsp_data = 0;
  logic [4:0] rs1 = 0, rs2 = 0;
  logic raw_stall, WE3, rsp_err;
  logic [4:0] AD3;
  logic [31:0] WD3;
  int n_cmp = 0, n_bad = 0;
  logic [4:0] pend[$];
  logic [36:0] sb[$];

  reg_writeback_seq dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rdy(ld_issue_rdy), .ld_rd(ld_rd),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
    .rs1(rs1), .rs2(rs2), .raw_stall(raw_stall),
    .AD3(AD3), .WE3(WE3), .WD3(WD3), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && WE3) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL write_unexpected: got AD3=%0d WD3=%h, required no write", AD3, WD3);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        if ({AD3, WD3} !== e) begin
          n_bad++;
          $display("FAIL write_order: got AD3=%0d WD3=%h, required AD3=%0d WD3=%h", AD3, WD3, e[36:32], e[31:0]);
        end
      end
    end
  end

  function automatic bit pmatch(input logic [4:0] r);
    if (r == 0) return 0;
    foreach (pend[i]) if (pend[i] == r) return 1;
    return 0;
  endfunction

  task automatic set_alu(input logic [4:0] r, input logic [31:0] d);
    alu_valid = 1; alu_rd = r; alu_data = d;
  endtask
  task automatic set_iss(input logic [4:0] r);
    ld_issue = 1; ld_rd = r;
  endtask
  task automatic set_rsp(input logic [31:0] d);
    ld_rsp_valid = 1; ld_rsp_data = d;
  endtask

  task automatic step();
    bit full, pop, acc;
    logic [4:0] r;
    full = pend.size() == 4;
    pop  = ld_rsp_valid && pend.size() != 0;
    acc  = alu_valid && !ld_rsp_valid && !pmatch(alu_rd);
    if (pop) begin
      r = pend.pop_front();
      if (r != 0) sb.push_back({r, ld_rsp_data});
    end else if (acc && alu_rd != 0) sb.push_back({alu_rd, alu_data});
    if (ld_issue && !full) pend.push_back(ld_rd);
    @(posedge clk); #1;
    alu_valid = 0; ld_issue = 0; ld_rsp_valid = 0;
  endtask

  task automatic test_reset();
    set_alu(5, 32'h1234);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (WE3 !== 1'b0) begin n_bad++; $display("FAIL reset_we3: got %b, required 0", WE3); end
    n_cmp++; if (AD3 !== 5'd0) begin n_bad++; $display("FAIL reset_ad3: got %0d, required 0", AD3); end
    n_cmp++; if (raw_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b, required 0", raw_stall); end
    n_cmp++; if (ld_issue_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy: got %b, required 1", ld_issue_rdy); end
    rst_n = 1;
    set_alu(5, 32'hDEAD);
    #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL alu_ready_idle: got %b, required 1", alu_ready); end
    step();
    n_cmp++; if ({WE3, AD3, WD3} !== {1'b1, 5'd5, 32'hDEAD})
      begin n_bad++; $display("FAIL alu_write: got WE3=%b AD3=%0d WD3=%h, required 1/5/dead", WE3, AD3, WD3); end
  endtask

  task automatic test_loads();
    set_iss(3); step();
    set_iss(4); step();
    rs1 = 4; #1;
    n_cmp++; if (raw_stall !== 1'b1) begin n_bad++; $display("FAIL raw_rs1: got %b, required 1", raw_stall); end
    set_rsp(32'h11); #1;
    n_cmp++; if (raw_stall !== 1'b1) begin n_bad++; $display("FAIL raw_popcycle: got %b, required 1", raw_stall); end
    step();
    set_rsp(32'h22); step();
    n_cmp++; if (raw_stall !== 1'b0) begin n_bad++; $display("FAIL raw_clear: got %b, required 0", raw_stall); end
    rs1 = 0;
  endtask

  task automatic test_arbitration();
    set_iss(6); step();
    set_rsp(32'h33); set_alu(7, 32'h77); #1;
    n_cmp++; if (alu_ready !== 1'b0) begin n_bad++; $display("FAIL arb_ready_lo: got %b, required 0", alu_ready); end
    step();
    n_cmp++; if ({AD3, WD3} !== {5'd6, 32'h33}) begin n_bad++; $display("FAIL arb_load_wins: got %0d/%h, required 6/33", AD3, WD3); end
    set_alu(7, 32'h77); #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL arb_ready_hi: got %b, required 1", alu_ready); end
    step();
    n_cmp++; if ({WE3, AD3, WD3} !== {1'b1, 5'd7, 32'h77}) begin n_bad++; $display("FAIL arb_alu_after: got %b/%0d/%h, required 1/7/77", WE3, AD3, WD3); end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 4; i++) begin set_iss(5'(10 + i)); step(); end
    n_cmp++; if (ld_issue_rdy !== 1'b0) begin n_bad++; $display("FAIL full_rdy: got %b, required 0", ld_issue_rdy); end
    set_iss(14); step();
    set_rsp(32'hA0); step();
    n_cmp++; if (ld_issue_rdy !== 1'b1) begin n_bad++; $display("FAIL cnt3_rdy: got %b, required 1", ld_issue_rdy); end
    set_rsp(32'hA1); set_iss(15); step();
    n_cmp++; if (ld_issue_rdy !== 1'b1) begin n_bad++; $display("FAIL pushpop_rdy: got %b, required 1", ld_issue_rdy); end
    set_iss(16); step();
    n_cmp++; if (ld_issue_rdy !== 1'b0) begin n_bad++; $display("FAIL refill_rdy: got %b, required 0", ld_issue_rdy); end
    for (int i = 0; i < 4; i++) begin set_rsp(32'hB0 + i); step(); end
    for (int i = 0; i < 6; i++) begin
      set_iss(5'(17 + i)); step();
      set_rsp(32'hC0 + i); step();
    end
    n_cmp++; if (ld_issue_rdy !== 1'b1) begin n_bad++; $display("FAIL wrap_rdy: got %b, required 1", ld_issue_rdy); end
  endtask

  task automatic test_x0_waw();
    set_iss(0); step();
    #1;
    n_cmp++; if (raw_stall !== 1'b0) begin n_bad++; $display("FAIL x0_no_stall: got %b, required 0", raw_stall); end
    set_alu(0, 32'hEE); #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL x0_alu_ready: got %b, required 1", alu_ready); end
    step();
    n_cmp++; if (WE3 !== 1'b0) begin n_bad++; $display("FAIL x0_alu_we: got %b, required 0", WE3); end
    set_rsp(32'hFF); step();
    n_cmp++; if (WE3 !== 1'b0) begin n_bad++; $display("FAIL x0_load_we: got %b, required 0", WE3); end
    set_iss(9); step();
    set_alu(9, 32'h5); #1;
    n_cmp++; if (alu_ready !== 1'b0) begin n_bad++; $display("FAIL waw_block: got %b, required 0", alu_ready); end
    step();
    set_rsp(32'h99); step();
    n_cmp++; if ({AD3, WD3} !== {5'd9, 32'h99}) begin n_bad++; $display("FAIL waw_load_first: got %0d/%h, required 9/99", AD3, WD3); end
    set_alu(9, 32'h5); #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL waw_release: got %b, required 1", alu_ready); end
    step();
  endtask

  task automatic test_err_reset();
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL err_pre: got %b, required 0", rsp_err); end
    set_rsp(32'hBAD); step();
    n_cmp++; if ({rsp_err, WE3} !== 2'b10) begin n_bad++; $display("FAIL err_set: got err=%b we=%b, required 1/0", rsp_err, WE3); end
    step();
    n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b, required 1", rsp_err); end
    set_iss(1); step();
    set_iss(2); set_alu(8, 32'h88); step();
    rs1 = 1; #1;
    n_cmp++; if (raw_stall !== 1'b1) begin n_bad++; $display("FAIL pre_reset_stall: got %b, required 1", raw_stall); end
    n_cmp++; if (WE3 !== 1'b1) begin n_bad++; $display("FAIL pre_reset_we: got %b, required 1", WE3); end
    rst_n = 0; #1;
    sb.delete(); pend.delete();
    n_cmp++; if ({WE3, rsp_err, ld_issue_rdy, raw_stall} !== 4'b0010)
      begin n_bad++; $display("FAIL async_reset: got we=%b err=%b rdy=%b stall=%b, required 0/0/1/0", WE3, rsp_err, ld_issue_rdy, raw_stall); end
    @(posedge clk); #1;
    rst_n = 1; rs1 = 0;
    set_rsp(32'h1); step();
    n_cmp++; if ({rsp_err, WE3} !== 2'b10) begin n_bad++; $display("FAIL post_reset_err: got err=%b we=%b, required 1/0", rsp_err, WE3); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_arbitration();
    test_full_wrap();
    test_x0_waw();
    test_err_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d writes missing, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
